vga_scan_ctrl: RTL and testbench
================================

Name: vga_scan_ctrl

Overview:
- Parametrised successor of the fixed 640x480 VGA controller/framebuffer pair in the NVBoard top.
- Generates H/V timing for any mode, and issues pixel read addresses to an external framebuffer memory of configurable read latency.
- Realigns sync, blank and RGB to the returned data.
- Adds a double-buffer select, switched only at frame boundaries, plus frame-start/frame-count outputs for software and test use.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
SYNC_POL, 0, sync active level (0 = active-low)
RD_LAT, 1, framebuffer read latency in clocks (0..4)
ADDR_W, 10, width of h_addr/v_addr
FCNT_W, 16, width of frame_cnt

Ports:
clk  in  1  pixel clock
resetn  in  1  asynchronous active-low reset
vga_data  in  24  framebuffer pixel {R,G,B}, valid RD_LAT clocks after rd_en
fb_sel_req  in  1  requested framebuffer (level)
rd_en  out  1  framebuffer read strobe (active region only)
h_addr  out  ADDR_W  pixel column of current read
v_addr  out  ADDR_W  pixel row of current read
fb_sel  out  1  framebuffer currently scanned (memory address MSB)
hsync  out  1  horizontal sync, aligned to RGB
vsync  out  1  vertical sync, aligned to RGB
valid  out  1  active video (BLANK_N), aligned to RGB
vga_r  out  8  red
vga_g  out  8  green
vga_b  out  8  blue
frame_start  out  1  one-clock pulse with first active pixel of a frame at the outputs
frame_cnt  out  FCNT_W  completed-frame counter

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- h_cnt runs 0..H_TOTAL-1 every clock. v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1.
- Line order: active [0,H_ACTIVE-1], front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], back porch. Vertical uses the same order in lines.
- Read stage (cycle 0):
  - rd_en = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - h_addr=h_cnt and v_addr=v_cnt when rd_en, else 0.
  - All three are registered from the counters, so they are combinational outputs of registers with no extra delay.
- Output stage:
  - hsync, vsync and valid are delayed RD_LAT clocks through a shift pipe, so they coincide with vga_data.
  - RD_LAT=0 means the memory is combinational and no delay is applied.
  - vga_r/g/b = vga_data fields when delayed valid=1, else 0.
  - Colour outputs are combinational from vga_data gated by the delayed valid.
- Sync polarity: asserted level = SYNC_POL; deasserted level = ~SYNC_POL.
- fb_sel:
  - fb_sel_req is sampled at h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1; fb_sel takes that value at the next clock (start of the frame).
  - Toggling fb_sel_req mid-frame has no effect until that boundary, so there is never tearing.
  - fb_sel is a read-stage signal (not delayed).
- frame_start: pulses 1 clock when the delayed pipe carries the read of pixel (0,0).
- frame_cnt: increments by 1 in the same clock as each frame_start after the first; wraps at 2^FCNT_W-1 -> 0.
- Reset (resetn=0, asynchronous), all pipe stages cleared:
  - h_cnt=v_cnt=0, rd_en=0, h_addr=v_addr=0, fb_sel=0.
  - hsync=vsync=~SYNC_POL, valid=0, RGB=0, frame_start=0, frame_cnt=0.
  - Release mid-line restarts timing at (0,0); the first frame_start occurs RD_LAT clocks after release plus one.
- Elaboration check: ADDR_W must hold H_TOTAL-1 and V_TOTAL-1; otherwise $error.

Test Plan:
- Small mode H=4/1/2/1, V=3/1/1/1, RD_LAT=0 -> hsync low at h_cnt 5,6 of each 8-clock line; vsync low for line 4 only; frame period 48 clocks; 12 valid pixels per frame with addresses (0..3, 0..2).
- RD_LAT=2, memory model returning {h_addr,v_addr} pattern -> vga_r/g/b match the pixel addressed 2 clocks earlier; hsync/valid edges shifted exactly 2 clocks vs rd_en; RGB=0 whenever valid=0.
- fb_sel_req toggled 0->1 at pixel (2,1) of frame 0 -> fb_sel stays 0 through frame 0 and becomes 1 at the first clock of frame 1; two toggles within one frame -> only the level at the last clock counts.
- Run 3 frames -> frame_start pulses exactly 3 times at 48-clock spacing; frame_cnt reads 0,1,2; with FCNT_W=2, 5 frames -> wraps 3->0.
- Assert resetn low mid-active-line for 3 clocks -> outputs go to reset values immediately (asynchronously, no clock needed); after release, rd_en first asserts at (0,0) and the sequence matches a fresh start.
- SYNC_POL=1, default 640x480 mode -> hsync high for 96 clocks starting at h_cnt 656; line period 800; frame period 420000 clocks.

Source files
------------

// File: rtl/vga_scan_ctrl.sv
// Parametrised VGA scan controller: free-running H/V timing, framebuffer read
// addressing, and sync/blank/RGB realignment to a fixed memory read latency.
module vga_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int RD_LAT   = 1,
  parameter int ADDR_W   = 10,
  parameter int FCNT_W   = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [23:0]       vga_data,
  input  logic              fb_sel_req,
  output logic              rd_en,
  output logic [ADDR_W-1:0] h_addr,
  output logic [ADDR_W-1:0] v_addr,
  output logic              fb_sel,
  output logic              hsync,
  output logic              vsync,
  output logic              valid,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [ADDR_W-1:0] H_LAST   = ADDR_W'(H_TOTAL - 1);
  localparam logic [ADDR_W-1:0] V_LAST   = ADDR_W'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] H_ACT    = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] V_ACT    = ADDR_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] HS_FIRST = ADDR_W'(H_ACTIVE + H_FP);
  localparam logic [ADDR_W-1:0] HS_LAST  = ADDR_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [ADDR_W-1:0] VS_FIRST = ADDR_W'(V_ACTIVE + V_FP);
  localparam logic [ADDR_W-1:0] VS_LAST  = ADDR_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic SYNC_ON = (SYNC_POL != 0);

  // Per-stage timing word: {active, hsync, vsync, first-pixel}
  localparam int B_ACT = 3;
  localparam int B_HS  = 2;
  localparam int B_VS  = 1;
  localparam int B_FS  = 0;
  localparam logic [3:0] ST_RESET = {1'b0, ~SYNC_ON, ~SYNC_ON, 1'b0};

  if ((H_TOTAL - 1) >= (1 << ADDR_W) || (V_TOTAL - 1) >= (1 << ADDR_W)) begin : g_addr_w_chk
    $error("vga_scan_ctrl: ADDR_W=%0d too narrow for H_TOTAL=%0d / V_TOTAL=%0d",
           ADDR_W, H_TOTAL, V_TOTAL);
  end

  if (RD_LAT < 0 || RD_LAT > 4) begin : g_rd_lat_chk
    $error("vga_scan_ctrl: RD_LAT=%0d outside 0..4", RD_LAT);
  end

  logic              run;
  logic [ADDR_W-1:0] h_cnt;
  logic [ADDR_W-1:0] v_cnt;
  logic [ADDR_W-1:0] h_nx;
  logic [ADDR_W-1:0] v_nx;
  logic              act_nx;
  logic              hs_nx;
  logic              vs_nx;
  logic              fs_nx;
  logic [3:0]        s_nx;
  logic              frame_end;
  logic              fs_load;
  logic              seen_first;
  logic [3:0]        st [0:RD_LAT];

  // The first clock after reset release only arms the scan, so (0,0) is
  // presented for a full clock rather than being skipped.
  always_comb begin
    h_nx = '0;
    v_nx = '0;
    if (run) begin
      if (h_cnt == H_LAST) begin
        h_nx = '0;
        v_nx = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_nx = h_cnt + 1'b1;
        v_nx = v_cnt;
      end
    end
    act_nx    = (h_nx < H_ACT) && (v_nx < V_ACT);
    hs_nx     = (h_nx >= HS_FIRST && h_nx <= HS_LAST) ? SYNC_ON : ~SYNC_ON;
    vs_nx     = (v_nx >= VS_FIRST && v_nx <= VS_LAST) ? SYNC_ON : ~SYNC_ON;
    fs_nx     = act_nx && (h_nx == '0) && (v_nx == '0);
    s_nx      = {act_nx, hs_nx, vs_nx, fs_nx};
    frame_end = run && (h_cnt == H_LAST) && (v_cnt == V_LAST);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run    <= 1'b0;
      h_cnt  <= '0;
      v_cnt  <= '0;
      h_addr <= '0;
      v_addr <= '0;
      fb_sel <= 1'b0;
      for (int i = 0; i <= RD_LAT; i++) st[i] <= ST_RESET;
    end else begin
      run    <= 1'b1;
      h_cnt  <= h_nx;
      v_cnt  <= v_nx;
      h_addr <= act_nx ? h_nx : '0;
      v_addr <= act_nx ? v_nx : '0;
      if (frame_end) fb_sel <= fb_sel_req;
      st[0] <= s_nx;
      for (int i = 1; i <= RD_LAT; i++) st[i] <= st[i-1];
    end
  end

  // fs_load is the first-pixel flag about to enter the output stage, so the
  // counter steps on the same edge that raises frame_start.
  if (RD_LAT == 0) begin : g_lat0
    assign fs_load = s_nx[B_FS];
  end else begin : g_latn
    assign fs_load = st[RD_LAT-1][B_FS];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seen_first <= 1'b0;
      frame_cnt  <= '0;
    end else if (fs_load) begin
      seen_first <= 1'b1;
      if (seen_first) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign rd_en       = st[0][B_ACT];
  assign hsync       = st[RD_LAT][B_HS];
  assign vsync       = st[RD_LAT][B_VS];
  assign valid       = st[RD_LAT][B_ACT];
  assign frame_start = st[RD_LAT][B_FS];
  assign vga_r       = valid ? vga_data[23:16] : 8'h00;
  assign vga_g       = valid ? vga_data[15:8]  : 8'h00;
  assign vga_b       = valid ? vga_data[7:0]   : 8'h00;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench: small mode at latency 0 and 2, plus 640x480 positive-sync line timing.
module tb_vga_scan_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic fb_sel_req = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // dut0: small mode, RD_LAT=0, FCNT_W=2
  logic [23:0] data0;
  logic        rd0, fb0, hs0, vs0, vl0, fs0;
  logic [9:0]  ha0, va0;
  logic [7:0]  r0, g0, b0;
  logic [1:0]  fc0;
  // dut2: small mode, RD_LAT=2
  logic [23:0] data2;
  logic        rd2, fb2, hs2, vs2, vl2, fs2;
  logic [9:0]  ha2, va2;
  logic [7:0]  r2, g2, b2;
  logic [15:0] fc2;
  // dut1: 640x480, SYNC_POL=1, RD_LAT=1
  logic [23:0] data1;
  logic        rd1, fb1, hs1, vs1, vl1, fs1;
  logic [9:0]  ha1, va1;
  logic [7:0]  r1, g1, b1;
  logic [15:0] fc1;

  function automatic logic [23:0] pix(input logic [9:0] h, input logic [9:0] v);
    return {h[7:0] + 8'd1, v[7:0] + 8'h40, 8'h5A};
  endfunction

  logic [23:0] m2a = '0, m2b = '0, m1a = '0;
  always @(posedge clk) begin
    m2a <= pix(ha2, va2);
    m2b <= m2a;
    m1a <= pix(ha1, va1);
  end
  assign data0 = pix(ha0, va0);
  assign data2 = m2b;
  assign data1 = m1a;

  vga_scan_ctrl #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                  .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                  .SYNC_POL(0), .RD_LAT(0), .ADDR_W(10), .FCNT_W(2)) dut0 (
    .clk(clk), .resetn(resetn), .vga_data(data0), .fb_sel_req(fb_sel_req),
    .rd_en(rd0), .h_addr(ha0), .v_addr(va0), .fb_sel(fb0), .hsync(hs0), .vsync(vs0),
    .valid(vl0), .vga_r(r0), .vga_g(g0), .vga_b(b0), .frame_start(fs0), .frame_cnt(fc0));

  vga_scan_ctrl #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                  .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                  .SYNC_POL(0), .RD_LAT(2), .ADDR_W(10), .FCNT_W(16)) dut2 (
    .clk(clk), .resetn(resetn), .vga_data(data2), .fb_sel_req(fb_sel_req),
    .rd_en(rd2), .h_addr(ha2), .v_addr(va2), .fb_sel(fb2), .hsync(hs2), .vsync(vs2),
    .valid(vl2), .vga_r(r2), .vga_g(g2), .vga_b(b2), .frame_start(fs2), .frame_cnt(fc2));

  vga_scan_ctrl #(.SYNC_POL(1), .RD_LAT(1)) dut1 (
    .clk(clk), .resetn(resetn), .vga_data(data1), .fb_sel_req(fb_sel_req),
    .rd_en(rd1), .h_addr(ha1), .v_addr(va1), .fb_sel(fb1), .hsync(hs1), .vsync(vs1),
    .valid(vl1), .vga_r(r1), .vga_g(g1), .vga_b(b1), .frame_start(fs1), .frame_cnt(fc1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  int cnt_fs0 = 0;
  int cnt_vl0 = 0;
  int cnt_hs1 = 0;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst rd_en", 32'(rd0), 0);
    chk("rst h_addr", 32'(ha0), 0);
    chk("rst v_addr", 32'(va0), 0);
    chk("rst fb_sel", 32'(fb0), 0);
    chk("rst hsync", 32'(hs0), 1);
    chk("rst vsync", 32'(vs0), 1);
    chk("rst valid", 32'(vl0), 0);
    chk("rst rgb", 32'({r0, g0, b0}), 0);
    chk("rst frame_start", 32'(fs0), 0);
    chk("rst frame_cnt", 32'(fc0), 0);
    chk("rst hsync pol1", 32'(hs1), 0);
    chk("rst vsync pol1", 32'(vs1), 0);
    chk("rst hsync lat2", 32'(hs2), 1);

    resetn = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 1737; k++) begin
      int p, h, v, a, q, hq, vq, aq, h1;
      if (k == 10)  fb_sel_req = 1'b1;
      if (k == 60)  fb_sel_req = 1'b0;
      if (k == 80)  fb_sel_req = 1'b1;
      if (k == 143) fb_sel_req = 1'b0;

      p = k % 48; h = p % 8; v = p / 8;
      a = (h < 4 && v < 3) ? 1 : 0;
      chk("l0 rd_en", 32'(rd0), 32'(a));
      chk("l0 h_addr", 32'(ha0), 32'(a != 0 ? h : 0));
      chk("l0 v_addr", 32'(va0), 32'(a != 0 ? v : 0));
      chk("l0 hsync", 32'(hs0), 32'((h == 5 || h == 6) ? 0 : 1));
      chk("l0 vsync", 32'(vs0), 32'((v == 4) ? 0 : 1));
      chk("l0 valid", 32'(vl0), 32'(a));
      chk("l0 rgb", 32'({r0, g0, b0}),
          a != 0 ? 32'({8'(h + 1), 8'(v + 8'h40), 8'h5A}) : 32'd0);
      chk("l0 frame_start", 32'(fs0), 32'(p == 0 ? 1 : 0));
      chk("l0 frame_cnt", 32'(fc0), 32'((k / 48) % 4));
      chk("fb_sel", 32'(fb0), 32'((k >= 48 && k < 144) ? 1 : 0));
      chk("fb_sel lat2", 32'(fb2), 32'((k >= 48 && k < 144) ? 1 : 0));

      chk("l2 rd_en", 32'(rd2), 32'(a));
      if (k < 2) begin
        hq = 0; vq = 0; aq = 0;
        chk("l2 hsync", 32'(hs2), 1);
        chk("l2 frame_start", 32'(fs2), 0);
        chk("l2 frame_cnt", 32'(fc2), 0);
      end else begin
        q = (k - 2) % 48; hq = q % 8; vq = q / 8;
        aq = (hq < 4 && vq < 3) ? 1 : 0;
        chk("l2 hsync", 32'(hs2), 32'((hq == 5 || hq == 6) ? 0 : 1));
        chk("l2 frame_start", 32'(fs2), 32'(q == 0 ? 1 : 0));
        chk("l2 frame_cnt", 32'(fc2), 32'((k - 2) / 48));
      end
      chk("l2 vsync", 32'(vs2), 32'((aq == 0 && vq == 4) ? 0 : 1));
      chk("l2 valid", 32'(vl2), 32'(aq));
      chk("l2 rgb", 32'({r2, g2, b2}),
          aq != 0 ? 32'({8'(hq + 1), 8'(vq + 8'h40), 8'h5A}) : 32'd0);

      h1 = (k - 1) % 800;
      chk("vga rd_en", 32'(rd1), 32'(((k % 800) < 640) ? 1 : 0));
      chk("vga hsync", 32'(hs1), 32'((k >= 1 && h1 >= 656 && h1 < 752) ? 1 : 0));
      chk("vga vsync", 32'(vs1), 0);
      chk("vga valid", 32'(vl1), 32'((k >= 1 && h1 < 640) ? 1 : 0));

      cnt_fs0 += int'(fs0);
      if (k < 48)  cnt_vl0 += int'(vl0);
      if (k < 800) cnt_hs1 += int'(hs1);
      @(negedge clk);
    end
    chk("frame_start count", 32'(cnt_fs0), 37);
    chk("valid pixels per frame", 32'(cnt_vl0), 12);
    chk("vga hsync width", 32'(cnt_hs1), 96);

    // cycle 1737: pixel (1,1) of dut0, mid active line
    chk("pre-rst rd_en", 32'(rd0), 1);
    chk("pre-rst h_addr", 32'(ha0), 1);
    chk("pre-rst vga rd_en", 32'(rd1), 1);
    chk("pre-rst frame_cnt lat2", 32'(fc2), 36);
    #2 resetn = 1'b0;
    #1;
    chk("async rd_en", 32'(rd0), 0);
    chk("async h_addr", 32'(ha0), 0);
    chk("async v_addr", 32'(va0), 0);
    chk("async valid", 32'(vl0), 0);
    chk("async rgb", 32'({r0, g0, b0}), 0);
    chk("async vga rd_en", 32'(rd1), 0);
    chk("async frame_cnt lat2", 32'(fc2), 0);
    chk("async valid lat2", 32'(vl2), 0);
    repeat (3) @(negedge clk);
    chk("held fb_sel", 32'(fb0), 0);
    resetn = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 50; j++) begin
      int p, h, v, a;
      p = j % 48; h = p % 8; v = p / 8;
      a = (h < 4 && v < 3) ? 1 : 0;
      chk("re rd_en", 32'(rd0), 32'(a));
      chk("re h_addr", 32'(ha0), 32'(a != 0 ? h : 0));
      chk("re v_addr", 32'(va0), 32'(a != 0 ? v : 0));
      chk("re frame_start", 32'(fs0), 32'(p == 0 ? 1 : 0));
      chk("re frame_cnt", 32'(fc0), 32'(j / 48));
      chk("re frame_start lat2", 32'(fs2), 32'((j == 2) ? 1 : 0));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
